// File: rtl/poll_entry_buffer.sv
// poll_entry_buffer: N-slot request buffer that presents its occupied slots to a poll_function
// arbiter and drains the granted slot. Define POLL_BUF_ERR_CHK_EN to add a sticky grant-error flag.
module poll_entry_buffer #(
  parameter int ENTRIES_NUM = 4,
  parameter int DATA_WIDTH  = 32,
  localparam int IDX_WIDTH  = (ENTRIES_NUM == 1) ? 1 : $clog2(ENTRIES_NUM),
  localparam int CNT_WIDTH  = $clog2(ENTRIES_NUM + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_WIDTH-1:0]  in_data,
  output logic [ENTRIES_NUM-1:0] pend_vec,
  input  logic                   grant_found,
  input  logic [ENTRIES_NUM-1:0] grant_entry,
  input  logic [IDX_WIDTH-1:0]   grant_index,
  output logic                   upd,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic [IDX_WIDTH-1:0]   out_index,
  output logic [CNT_WIDTH-1:0]   count
`ifdef POLL_BUF_ERR_CHK_EN
  ,
  output logic                   err
`endif
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are both 1; valid never
  // depends on ready of the same port, and ready/valid may be dropped freely between transfers.

  logic [ENTRIES_NUM-1:0] valid_q, valid_d;
  logic [DATA_WIDTH-1:0]  data_q [ENTRIES_NUM];
  logic [DATA_WIDTH-1:0]  data_d [ENTRIES_NUM];
  logic [CNT_WIDTH-1:0]   count_q, count_d;
  logic [ENTRIES_NUM-1:0] free_vec;
  logic [ENTRIES_NUM-1:0] alloc_oh;
  logic [ENTRIES_NUM-1:0] deq_mask;
  logic                   wr_en;
  logic                   deq_en;
  logic                   grant_legal;

  // Allocation looks only at pre-edge occupancy, so a slot freed this cycle is not reused yet.
  always_comb begin
    free_vec = ~valid_q;
    alloc_oh = free_vec & (~free_vec + ENTRIES_NUM'(1));
    in_ready = |free_vec;
    wr_en    = in_valid & in_ready;
  end

  always_comb begin
    grant_legal = grant_found & (|grant_entry) & ~(|(grant_entry & ~valid_q));
    out_valid   = grant_legal;
    upd         = grant_legal & out_ready;
    deq_en      = upd;
    deq_mask    = deq_en ? grant_entry : '0;
  end

  always_comb begin
    out_data = '0;
    for (int i = 0; i < ENTRIES_NUM; i++) begin
      out_data = out_data | (data_q[i] & {DATA_WIDTH{grant_entry[i]}});
    end
  end

  assign out_index = grant_index;
  assign pend_vec  = valid_q;
  assign count     = count_q;

  always_comb begin
    valid_d = (valid_q & ~deq_mask) | (wr_en ? alloc_oh : '0);
    case ({wr_en, deq_en})
      2'b10:   count_d = count_q + CNT_WIDTH'(1);
      2'b01:   count_d = count_q - CNT_WIDTH'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    for (int i = 0; i < ENTRIES_NUM; i++) begin
      data_d[i] = (wr_en && alloc_oh[i]) ? in_data : data_q[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  // Payload storage carries no reset; occupancy alone decides what is meaningful.
  always_ff @(posedge clk) begin
    for (int i = 0; i < ENTRIES_NUM; i++) begin
      data_q[i] <= data_d[i];
    end
  end

`ifdef POLL_BUF_ERR_CHK_EN
  logic err_q, err_d;
  logic grant_onehot;

  always_comb begin
    grant_onehot = (grant_entry != '0) &&
                   ((grant_entry & (grant_entry - ENTRIES_NUM'(1))) == '0);
    err_d        = err_q | (grant_found & (~grant_onehot | (|(grant_entry & ~valid_q))));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err = err_q;
`endif

endmodule
